adder_pipe_nbit: RTL and testbench

- Parametrised, pipelined successor to the n-bit ripple-carry adder.
- Splits a BIT_WIDTH-bit add into STAGES = BIT_WIDTH/SLICE_WIDTH carry-registered slices, so wide adds can close timing.
- Uses a valid/ready handshake on input and output. One add is accepted per cycle; results come out in order.
- Sits between operand-producing datapath logic and any consumer that can apply backpressure.

---
 rtl/adder_pipe_nbit.sv | 178 +++++++++++++++++
 tb/tb_adder_pipe_nbit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbit
//
// Pipelined unsigned adder: a BIT_WIDTH-bit add is cut into
// STAGES = BIT_WIDTH/SLICE_WIDTH slices. Stage k adds slice k of the operands
// with the carry registered by stage k-1, so the longest carry chain is one
// slice wide.
//
// Handshake (both sides): a transfer happens at a rising clock edge where
// valid && ready are both high. The producer must hold in_valid and the
// operands until it sees in_ready. in_ready does not depend on in_valid.
// sum/overflow are stable while out_valid=1 and out_ready=0.
//
// The pipeline moves as one unit under a single enable
// (adv = !out_valid || out_ready). Bubbles are not collapsed.
//
// Optional feature, macro ADDER_PIPE_SIGNED_OVF_EN:
//   when defined, adds a registered signed_overflow output that is aligned
//   with sum. It treats the operands as two's complement. When the macro is
//   undefined, the port and its registers do not exist.
// -----------------------------------------------------------------------------
module adder_pipe_nbit #(
   parameter int BIT_WIDTH   = 16,
   parameter int SLICE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] sum,
`ifdef ADDER_PIPE_SIGNED_OVF_EN
   output logic                 signed_overflow,
`endif
   output logic                 overflow
);

   localparam int STAGES = BIT_WIDTH / SLICE_WIDTH;
   localparam int LAST   = STAGES - 1;

   // Reject geometries that cannot be sliced evenly.
   if ((SLICE_WIDTH < 1) || (SLICE_WIDTH > BIT_WIDTH) ||
       ((BIT_WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_params
      $error("adder_pipe_nbit: BIT_WIDTH must be a positive multiple of SLICE_WIDTH");
   end

   // ---------------------------------------------------------------------------
   // Per-stage registers
   //   r_acc   : accumulated sum, slices 0..k filled in, upper slices zero
   //   r_opa/b : operands carried forward; stage k+1 reads slice k+1 of them
   //   r_carry : carry out of the slice added in this stage
   //   r_valid : this stage holds a real add (0 = bubble)
   // ---------------------------------------------------------------------------
   logic [BIT_WIDTH-1:0] r_acc [STAGES];
   logic [BIT_WIDTH-1:0] r_opa [STAGES];
   logic [BIT_WIDTH-1:0] r_opb [STAGES];
   logic [STAGES-1:0]    r_carry;
   logic [STAGES-1:0]    r_valid;

`ifdef ADDER_PIPE_SIGNED_OVF_EN
   // Operand sign bits travel with the add so the final stage can judge the
   // sign of the result against them.
   logic [STAGES-1:0]    r_amsb;
   logic [STAGES-1:0]    r_bmsb;
   logic                 r_sovf;
   logic [STAGES-1:0]    w_amsb_in;
   logic [STAGES-1:0]    w_bmsb_in;
   logic                 w_sovf_nx;
`endif

   // ---------------------------------------------------------------------------
   // Per-stage combinational inputs and results
   // ---------------------------------------------------------------------------
   logic [BIT_WIDTH-1:0] w_a_in     [STAGES];
   logic [BIT_WIDTH-1:0] w_b_in     [STAGES];
   logic [BIT_WIDTH-1:0] w_acc_in   [STAGES];
   logic [BIT_WIDTH-1:0] w_acc_nx   [STAGES];
   logic [SLICE_WIDTH:0] w_slice    [STAGES];
   logic [STAGES-1:0]    w_c_in;
   logic [STAGES-1:0]    w_v_in;
   logic                 w_adv;

   // Global advance: the last stage can move on if it is empty or being taken.
   assign w_adv = !r_valid[LAST] || out_ready;

   // Stage inputs: stage 0 takes the ports, every other stage its predecessor.
   always_comb begin
      w_a_in[0]   = a;
      w_b_in[0]   = b;
      w_acc_in[0] = '0;
      w_c_in[0]   = carry_in;
      w_v_in[0]   = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k]   = r_opa[k-1];
         w_b_in[k]   = r_opb[k-1];
         w_acc_in[k] = r_acc[k-1];
         w_c_in[k]   = r_carry[k-1];
         w_v_in[k]   = r_valid[k-1];
      end
   end

   // Slice add per stage: one SLICE_WIDTH-bit add plus the incoming carry,
   // with the result dropped into this stage's slot of the accumulated sum.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_slice[k]  = {1'b0, w_a_in[k][k*SLICE_WIDTH +: SLICE_WIDTH]}
                     + {1'b0, w_b_in[k][k*SLICE_WIDTH +: SLICE_WIDTH]}
                     + {{SLICE_WIDTH{1'b0}}, w_c_in[k]};
         w_acc_nx[k] = w_acc_in[k];
         w_acc_nx[k][k*SLICE_WIDTH +: SLICE_WIDTH] = w_slice[k][SLICE_WIDTH-1:0];
      end
   end

   // Pipeline registers: clear on reset, load from predecessor on advance,
   // otherwise hold everything including the valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_acc[k] <= '0;
            r_opa[k] <= '0;
            r_opb[k] <= '0;
         end
         r_carry <= '0;
         r_valid <= '0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_acc[k]   <= w_acc_nx[k];
            r_opa[k]   <= w_a_in[k];
            r_opb[k]   <= w_b_in[k];
            r_carry[k] <= w_slice[k][SLICE_WIDTH];
            r_valid[k] <= w_v_in[k];
         end
      end
   end

`ifdef ADDER_PIPE_SIGNED_OVF_EN
   // Sign bits entering each stage, stage 0 straight from the operands.
   always_comb begin
      w_amsb_in[0] = a[BIT_WIDTH-1];
      w_bmsb_in[0] = b[BIT_WIDTH-1];
      for (int k = 1; k < STAGES; k++) begin
         w_amsb_in[k] = r_amsb[k-1];
         w_bmsb_in[k] = r_bmsb[k-1];
      end
   end

   // Signed overflow: same-sign operands giving a result of the other sign.
   // Evaluated on the final stage's incoming sum so the flag lands with it.
   assign w_sovf_nx = (w_amsb_in[LAST] == w_bmsb_in[LAST]) &&
                      (w_acc_nx[LAST][BIT_WIDTH-1] != w_amsb_in[LAST]);

   // Sign-bit pipeline and the registered flag share the global advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_amsb <= '0;
         r_bmsb <= '0;
         r_sovf <= 1'b0;
      end else if (w_adv) begin
         r_amsb <= w_amsb_in;
         r_bmsb <= w_bmsb_in;
         r_sovf <= w_sovf_nx;
      end
   end

   assign signed_overflow = r_sovf;
`endif

   // Outputs come straight from the last stage's registers.
   assign in_ready  = w_adv;
   assign out_valid = r_valid[LAST];
   assign sum       = r_acc[LAST];
   assign overflow  = r_carry[LAST];

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_nbit
//
// Drives adds into adder_pipe_nbit and checks every result. The reference
// model is plain integer arithmetic on the operands. Expected results are
// queued when an input transfer is seen. A negedge monitor pops the queue on
// each output transfer and compares sum, overflow and latency.
// The macro ADDER_PIPE_SIGNED_OVF_EN also enables signed_overflow checking.
// -----------------------------------------------------------------------------
module tb_adder_pipe_nbit;

   localparam int BW     = 16;
   localparam int SW     = 4;
   localparam int STAGES = BW / SW;
   localparam int W      = 64 + 2 + BW;   // {issue_cycle, stall_snap, sovf, ovf, sum}

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] a;
   logic [BW-1:0] b;
   logic          carry_in;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] sum;
   logic          overflow;
`ifdef ADDER_PIPE_SIGNED_OVF_EN
   logic          signed_overflow;
`endif

   always #5 clk = ~clk;

   adder_pipe_nbit #(.BIT_WIDTH(BW), .SLICE_WIDTH(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef ADDER_PIPE_SIGNED_OVF_EN
      .signed_overflow (signed_overflow),
`endif
      .overflow  (overflow)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           n_cmp       = 0;
   int           n_fail      = 0;
   int           cycle       = 0;
   int           stall_total = 0;
   logic         prev_stall  = 1'b0;
   logic [BW-1:0] held_sum;
   logic          held_ovf;
   logic          rand_done;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference model: unsigned and two's-complement sums in wide integers.
   function automatic logic [W-1:0] model(input logic [BW-1:0] op_a, input logic [BW-1:0] op_b,
                                          input logic op_c, input int t_issue, input int t_stall);
      longint u, s, lim;
      logic   m_ovf, m_sovf;
      logic [BW-1:0] m_sum;
      u      = longint'(op_a) + longint'(op_b) + longint'(op_c);
      m_sum  = u[BW-1:0];
      m_ovf  = (u >= (longint'(1) << BW));
      lim    = longint'(1) << (BW - 1);
      s      = longint'($signed(op_a)) + longint'($signed(op_b)) + longint'(op_c);
      m_sovf = (s >= lim) || (s < -lim);
      return {t_issue, t_stall, m_sovf, m_ovf, m_sum};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      int           e_issue, e_snap;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready", in_ready, (!out_valid || out_ready));
         if (prev_stall) begin
            check("held_sum", sum, held_sum);
            check("held_ovf", overflow, held_ovf);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", out_valid, 0);
            end else if (out_ready) begin
               e       = exp_q.pop_front();
               e_issue = e[W-1 -: 32];
               e_snap  = e[W-33 -: 32];
               check("sum", sum, e[BW-1:0]);
               check("overflow", overflow, e[BW]);
`ifdef ADDER_PIPE_SIGNED_OVF_EN
               check("signed_overflow", signed_overflow, e[BW+1]);
`endif
               check("latency", cycle, e_issue + STAGES + (stall_total - e_snap));
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(a, b, carry_in, cycle, stall_total));
         prev_stall = out_valid && !out_ready;
         if (prev_stall) begin
            stall_total++;
            held_sum = sum;
            held_ovf = overflow;
         end
      end
      cycle++;
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [BW-1:0] op_a, input logic [BW-1:0] op_b, input logic op_c);
      int guard = 0;
      in_valid = 1'b1;
      a        = op_a;
      b        = op_b;
      carry_in = op_c;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int guard = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && guard < 300) begin
         guard++;
         @(posedge clk); #1;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      idle(2);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b0;
      rand_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_overflow", overflow, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef ADDER_PIPE_SIGNED_OVF_EN
      check("rst_signed_overflow", signed_overflow, 0);
`endif
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Single add, carry through all slices, signed overflow case
      send(16'h1234, 16'h4321, 1'b0); drain();
      send(16'hFFFF, 16'h0000, 1'b1); drain();
      send(16'h7FFF, 16'h0001, 1'b0); drain();

      // Back-to-back stream
      for (int i = 0; i < 8; i++) send(BW'(i), BW'(i * 2), 1'b0);
      drain();

      // Backpressure mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(BW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
         end
         begin
            repeat (5) begin @(posedge clk); #1; end
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               check("bp_out_valid", out_valid, 1);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with adds in flight, then a fresh add
      for (int i = 0; i < 3; i++) send(BW'($urandom), BW'($urandom), 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(8);
      send(16'h0F0F, 16'h00F1, 1'b1); drain();

      // Randomised traffic with random gaps and random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(BW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            in_valid  = 1'b0;
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
